// File: rtl/wb_uart_dbg_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------------
// wb_uart_dbg_bridge: 8N1 serial command port that issues single 32-bit Wishbone cycles
// Rev 1.0
// ----------------------------------------------------------------------------------
module wb_uart_dbg_bridge #(
   parameter int CLKS_PER_BIT  = 16,
   parameter int BUS_TIMEOUT   = 64,
   parameter int BYTE_TIMEOUT  = 4096,
   parameter int WB_ADDR_WIDTH = 32,
   parameter int WB_DATA_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [WB_ADDR_WIDTH-1:0] wb_adr,
   output logic [WB_DATA_WIDTH-1:0] wb_dat_w,
   input  logic [WB_DATA_WIDTH-1:0] wb_dat_r,
   output logic                     wb_cyc,
   output logic                     wb_stb,
   output logic                     wb_we,
   output logic [3:0]               wb_sel,
   input  logic                     wb_ack,
   input  logic                     wb_err,
   input  logic                     rx_i,
   output logic                     tx_o,
   output logic                     busy_o
);

   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CW       = $clog2(CLKS_PER_BIT);
   localparam int BTW      = $clog2(BUS_TIMEOUT);
   localparam int TOW      = $clog2(BYTE_TIMEOUT);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_BUS, P_RESP} p_state_t;

   rx_state_t       rx_state, rx_next;
   logic            rx_meta, rx_sync, rx_prev;
   logic [CW-1:0]   rx_cnt;
   logic [2:0]      rx_bit;
   logic [7:0]      rx_shift;
   logic            rx_valid, rx_ferr;
   logic            rx_half, rx_full;

   logic [9:0]      tx_shift;
   logic            tx_active;
   logic [CW-1:0]   tx_cnt;
   logic [3:0]      tx_bits;
   logic            tx_last, tx_ready, tx_load;

   p_state_t        p_state, p_next;
   logic            we, cyc;
   logic [1:0]      idx;
   logic [31:0]     addr, wdata, resp_buf;
   logic [2:0]      resp_left;
   logic [TOW-1:0]  to_cnt;
   logic [BTW-1:0]  bus_cnt;
   logic            bus_done, byte_to;

   // ------------------------------------------------------------------ RX
   assign rx_half = (rx_cnt == CW'(HALF_BIT - 1));
   assign rx_full = (rx_cnt == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rx_state <= RX_IDLE;
      else     rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
         // a start bit that is high again at its midpoint was only a glitch
         RX_START: if (rx_half) rx_next = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_full && rx_bit == 3'd7) rx_next = RX_STOP;
         RX_STOP:  if (rx_full) rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         if (rx_state == RX_IDLE || (rx_state == RX_START && rx_half) || rx_full)
            rx_cnt <= '0;
         else
            rx_cnt <= rx_cnt + 1'b1;
         if (rx_state == RX_IDLE)
            rx_bit <= '0;
         if (rx_state == RX_DATA && rx_full) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
         end
         if (rx_state == RX_STOP && rx_full) begin
            rx_valid <= rx_sync;
            rx_ferr  <= !rx_sync;
         end
      end
   end

   // ------------------------------------------------------------------ TX
   // A new byte may load in the final stop-bit cycle so replies run back to back.
   assign tx_last  = tx_active && (tx_cnt == CW'(CLKS_PER_BIT - 1)) && (tx_bits == 4'd9);
   assign tx_ready = !tx_active || tx_last;
   assign tx_o     = tx_shift[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_shift  <= '1;
         tx_active <= 1'b0;
         tx_cnt    <= '0;
         tx_bits   <= '0;
      end else if (tx_load) begin
         tx_shift  <= {1'b1, resp_buf[31:24], 1'b0};
         tx_active <= 1'b1;
         tx_cnt    <= '0;
         tx_bits   <= '0;
      end else if (tx_active) begin
         if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b1, tx_shift[9:1]};
            tx_bits  <= tx_bits + 1'b1;
            if (tx_bits == 4'd9) tx_active <= 1'b0;
         end else begin
            tx_cnt <= tx_cnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------ parser / bus sequencer
   assign bus_done = cyc && (wb_ack || wb_err || bus_cnt == BTW'(BUS_TIMEOUT - 1));
   assign byte_to  = (to_cnt == TOW'(BYTE_TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) p_state <= P_IDLE;
      else     p_state <= p_next;
   end

   always_comb begin
      p_next  = p_state;
      tx_load = 1'b0;
      case (p_state)
         P_IDLE: if (rx_valid) p_next = (rx_shift == 8'h57 || rx_shift == 8'h52) ? P_ADDR : P_RESP;
         P_ADDR: begin
            if (rx_ferr)                      p_next = P_IDLE;
            else if (rx_valid)                p_next = (idx == 2'd3) ? (we ? P_DATA : P_BUS) : P_ADDR;
            else if (byte_to)                 p_next = P_IDLE;
         end
         P_DATA: begin
            if (rx_ferr)                      p_next = P_IDLE;
            else if (rx_valid)                p_next = (idx == 2'd3) ? P_BUS : P_DATA;
            else if (byte_to)                 p_next = P_IDLE;
         end
         P_BUS:  if (bus_done) p_next = P_RESP;
         P_RESP: begin
            if (resp_left != 3'd0) tx_load = tx_ready;
            else if (!tx_active)   p_next  = P_IDLE;
         end
         default: p_next = P_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we        <= 1'b0;
         cyc       <= 1'b0;
         idx       <= '0;
         addr      <= '0;
         wdata     <= '0;
         resp_buf  <= '0;
         resp_left <= '0;
         to_cnt    <= '0;
         bus_cnt   <= '0;
      end else begin
         if (rx_valid || !(p_state == P_ADDR || p_state == P_DATA))
            to_cnt <= '0;
         else
            to_cnt <= to_cnt + 1'b1;
         case (p_state)
            P_IDLE: if (rx_valid) begin
               // NAK is preloaded; a valid opcode overwrites it after the bus cycle
               we        <= (rx_shift == 8'h57);
               idx       <= '0;
               resp_buf  <= {8'h15, 24'h0};
               resp_left <= 3'd1;
            end
            P_ADDR: if (rx_valid) begin
               addr <= {addr[23:0], rx_shift};
               idx  <= idx + 1'b1;
            end
            P_DATA: if (rx_valid) begin
               wdata <= {wdata[23:0], rx_shift};
               idx   <= idx + 1'b1;
            end
            P_BUS: begin
               if (!cyc) begin
                  cyc     <= 1'b1;
                  bus_cnt <= '0;
               end else if (bus_done) begin
                  cyc <= 1'b0;
                  if (wb_ack && !wb_err) begin
                     resp_buf  <= we ? {8'h06, 24'h0} : 32'(wb_dat_r);
                     resp_left <= we ? 3'd1 : 3'd4;
                  end else begin
                     resp_buf  <= {8'h15, 24'h0};
                     resp_left <= 3'd1;
                  end
               end else begin
                  bus_cnt <= bus_cnt + 1'b1;
               end
            end
            P_RESP: if (tx_load) begin
               resp_buf  <= {resp_buf[23:0], 8'h00};
               resp_left <= resp_left - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign wb_cyc   = cyc;
   assign wb_stb   = cyc;
   assign wb_we    = cyc & we;
   assign wb_sel   = {4{cyc}};
   assign wb_adr   = WB_ADDR_WIDTH'(addr);
   assign wb_dat_w = WB_DATA_WIDTH'(wdata);
   assign busy_o   = (p_state != P_IDLE) || tx_active;

endmodule
`default_nettype wire

// File: tb/tb_wb_uart_dbg_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------------
// tb_wb_uart_dbg_bridge: scoreboard bench for the serial-to-Wishbone debug bridge
// Rev 1.0
// ----------------------------------------------------------------------------------
module tb_wb_uart_dbg_bridge;
   localparam int CPB  = 16;
   localparam int BTO  = 64;
   localparam int BYTO = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx  = 1'b1;
   logic        tx_o, busy_o;
   logic [31:0] wb_adr, wb_dat_w;
   logic [31:0] slv_rdata = 32'h0;
   logic        wb_cyc, wb_stb, wb_we;
   logic [3:0]  wb_sel;
   logic        wb_ack = 1'b0;
   logic        wb_err = 1'b0;

   wb_uart_dbg_bridge #(
      .CLKS_PER_BIT(CPB), .BUS_TIMEOUT(BTO), .BYTE_TIMEOUT(BYTO),
      .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)
   ) dut (
      .clk(clk), .rst(rst),
      .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(slv_rdata),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
      .wb_ack(wb_ack), .wb_err(wb_err),
      .rx_i(rx), .tx_o(tx_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
      logic        we;
      logic [7:0]  len;
   } bus_exp_t;

   bus_exp_t   q_bus[$];
   logic [7:0] q_tx[$];
   int checks   = 0;
   int failures = 0;
   int cyc_n    = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Slave: kind 0=ACK, 1=ERR, 2=silent, 3=ACK+ERR together; responds in cycle delay+1 of CYC
   int slv_kind  = 2;
   int slv_delay = 1;
   int scnt      = 0;
   always @(posedge clk) begin
      if (rst || !wb_cyc) begin
         wb_ack <= 1'b0; wb_err <= 1'b0; scnt <= 0;
      end else if (wb_ack || wb_err) begin
         wb_ack <= 1'b0; wb_err <= 1'b0;
      end else begin
         scnt <= scnt + 1;
         if (slv_kind != 2 && scnt + 1 == slv_delay) begin
            wb_ack <= (slv_kind == 0 || slv_kind == 3);
            wb_err <= (slv_kind == 1 || slv_kind == 3);
         end
      end
   end

   // Bus monitor
   logic        bm_act = 1'b0;
   logic        lat_pend = 1'b0;
   int          bm_len, fall_n;
   logic [31:0] bm_adr, bm_dat;
   logic        bm_we;
   logic [3:0]  bm_sel;
   bus_exp_t    be;
   always @(negedge clk) begin
      if (rst) begin
         bm_act = 1'b0; lat_pend = 1'b0;
      end else if (wb_cyc) begin
         if (!bm_act) begin
            bm_act = 1'b1; bm_len = 1;
            bm_adr = wb_adr; bm_dat = wb_dat_w; bm_we = wb_we; bm_sel = wb_sel;
            check("bus_stb", wb_stb, 1);
         end else begin
            bm_len++;
         end
      end else if (bm_act) begin
         bm_act = 1'b0; lat_pend = 1'b1; fall_n = cyc_n;
         check("bus_cycle_expected", q_bus.size() != 0, 1);
         if (q_bus.size() != 0) begin
            be = q_bus.pop_front();
            check("bus_adr", bm_adr, be.adr);
            check("bus_we", bm_we, be.we);
            if (be.we) check("bus_dat_w", bm_dat, be.dat);
            check("bus_sel", bm_sel, 4'hF);
            check("bus_len", bm_len, be.len);
         end
      end
   end

   // TX monitor: decodes frames at mid-bit
   logic       tm_act = 1'b0;
   logic       tm_prev = 1'b1;
   int         tm_t;
   logic [7:0] tm_byte;
   always @(negedge clk) begin
      if (rst) begin
         tm_act = 1'b0; tm_prev = 1'b1;
      end else begin
         if (!tm_act) begin
            if (tm_prev && !tx_o) begin
               tm_act = 1'b1; tm_t = 0;
               if (lat_pend) begin
                  check("tx_start_latency", cyc_n - fall_n, 1);
                  lat_pend = 1'b0;
               end
            end
         end else begin
            tm_t++;
            if (tm_t == CPB/2) check("tx_start_bit", tx_o, 0);
            if (tm_t >= CPB/2 + CPB && tm_t <= CPB/2 + 8*CPB && (tm_t - CPB/2) % CPB == 0)
               tm_byte[(tm_t - CPB/2) / CPB - 1] = tx_o;
            if (tm_t == CPB/2 + 9*CPB) begin
               tm_act = 1'b0;
               check("tx_stop_bit", tx_o, 1);
               check("tx_byte_expected", q_tx.size() != 0, 1);
               if (q_tx.size() != 0) check("tx_byte", tm_byte, q_tx.pop_front());
            end
         end
         tm_prev = tx_o;
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   // Reference model: one command -> one bus cycle and the reply bytes it must produce
   task automatic issue(input logic w, input logic [31:0] adr, input logic [31:0] dat,
                        input int kind, input int delay, input logic [31:0] rdata);
      bus_exp_t e;
      slv_kind = kind; slv_delay = delay; slv_rdata = rdata;
      e.adr = adr; e.dat = dat; e.we = w;
      e.len = (kind == 2) ? 8'(BTO) : 8'(delay + 1);
      q_bus.push_back(e);
      if (kind == 0) begin
         if (w) q_tx.push_back(8'h06);
         else for (int i = 3; i >= 0; i--) q_tx.push_back(rdata[8*i +: 8]);
      end else begin
         q_tx.push_back(8'h15);
      end
      send_byte(w ? 8'h57 : 8'h52, 1'b1);
      for (int i = 3; i >= 0; i--) send_byte(adr[8*i +: 8], 1'b1);
      if (w) for (int i = 3; i >= 0; i--) send_byte(dat[8*i +: 8], 1'b1);
   endtask

   task automatic wait_done(input string what);
      int n = 0;
      while ((q_tx.size() != 0 || q_bus.size() != 0 || busy_o) && n < 6000) begin
         @(negedge clk); n++;
      end
      check({what, "_done_in_time"}, n < 6000, 1);
      repeat (CPB) @(negedge clk);
   endtask

   task automatic reset_pulse(input string what);
      #2 rst = 1'b1;
      #1;
      check({what, "_rst_tx"}, tx_o, 1);
      check({what, "_rst_cyc"}, wb_cyc, 0);
      check({what, "_rst_stb"}, wb_stb, 0);
      check({what, "_rst_busy"}, busy_o, 0);
      q_tx.delete(); q_bus.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (CPB) @(negedge clk);
   endtask

   initial begin
      int n;
      logic [7:0] b;
      repeat (3) @(negedge clk);
      check("reset_tx", tx_o, 1);
      check("reset_busy", busy_o, 0);
      check("reset_cyc", wb_cyc, 0);
      check("reset_stb", wb_stb, 0);
      check("reset_we", wb_we, 0);
      check("reset_adr", wb_adr, 0);
      check("reset_dat_w", wb_dat_w, 0);
      check("reset_sel", wb_sel, 0);
      rst = 1'b0;
      repeat (CPB) @(negedge clk);

      issue(1'b1, 32'h10000004, 32'hDEADBEEF, 0, 3, 32'h0);
      wait_done("write");

      issue(1'b0, 32'h10000004, 32'h0, 0, 2, 32'hCAFEF00D);
      n = 0;
      while (q_tx.size() != 0 && n < 4000) begin @(negedge clk); n++; end
      check("read_reply_in_time", n < 4000, 1);
      check("busy_during_last_stop", busy_o, 1);
      wait_done("read");
      check("tx_idle_after_read", tx_o, 1);

      q_tx.push_back(8'h15);
      send_byte(8'h41, 1'b1);
      wait_done("bad_cmd");
      issue(1'b0, 32'h10000004, 32'h0, 0, 1, 32'hCAFEF00D);
      wait_done("read_after_nak");

      issue(1'b0, 32'h20000000, 32'h0, 2, 1, 32'h0);
      wait_done("bus_timeout");
      issue(1'b0, 32'h20000000, 32'h0, 1, 1, 32'h0);
      wait_done("bus_err");
      issue(1'b1, 32'h30000008, 32'h01234567, 3, 2, 32'h0);
      wait_done("ack_err_both");

      send_byte(8'h57, 1'b1);
      send_byte(8'h10, 1'b1);
      repeat (5000) @(negedge clk);
      check("busy_after_byte_timeout", busy_o, 0);

      send_byte(8'h57, 1'b1);
      send_byte(8'h10, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h04, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      check("busy_after_framing_err", busy_o, 0);
      issue(1'b1, 32'h10000008, 32'h55AA55AA, 0, 2, 32'h0);
      wait_done("write_after_framing");

      issue(1'b0, 32'h10000010, 32'h0, 0, 1, 32'h89ABCDEF);
      n = 0;
      while (tx_o && n < 2000) begin @(negedge clk); n++; end
      check("tx_started_before_reset", n < 2000, 1);
      repeat (3 * CPB) @(negedge clk);
      reset_pulse("mid_tx");

      issue(1'b0, 32'h20000000, 32'h0, 2, 1, 32'h0);
      n = 0;
      while (!wb_cyc && n < 200) begin @(negedge clk); n++; end
      check("cyc_before_reset", n < 200, 1);
      repeat (10) @(negedge clk);
      reset_pulse("mid_bus");

      issue(1'b1, 32'h10000000, 32'hA5A5F00F, 0, 1, 32'h0);
      wait_done("write_after_reset");

      for (int k = 0; k < 10; k++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r == 0) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h57 || b == 8'h52) b = 8'h41;
            q_tx.push_back(8'h15);
            send_byte(b, 1'b1);
            wait_done("rand_bad_cmd");
         end else begin
            issue(1'($urandom_range(0, 1)), $urandom, $urandom,
                  (r <= 6) ? 0 : r - 6, int'($urandom_range(1, 6)), $urandom);
            wait_done("rand_cmd");
         end
      end

      check("scoreboard_empty", q_tx.size() + q_bus.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
